addsub_result_queue: RTL and testbench

ADDSUB_RESULT_QUEUE -- requirements
Module: addsub_result_queue

---
 rtl/addsub_pkg.sv | 26 ++
 rtl/addsub_flag_gen.sv | 34 +++
 rtl/addsub_result_queue.sv | 143 ++++++++++++++
 tb/tb_addsub_result_queue.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub result queue: default width, flag bit
// positions inside the 4-bit {C,V,N,Z} word, and a saturating counter helper.
package addsub_pkg;

    localparam int ADDSUB_DATA_W = 16;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;
    localparam int FLAG_W = 4;

    // Packed flag word; index with the FLAG_* constants.
    typedef logic [FLAG_W-1:0] flags_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/addsub_flag_gen.sv
// Combinational {C,V,N,Z} flag generation for an add/sub result, computed from
// the result, carry-out and the operand sign bits.
module addsub_flag_gen
    import addsub_pkg::*;
#(
    parameter int DATA_W = ADDSUB_DATA_W
) (
    input  logic [DATA_W-1:0] sum,
    input  logic              cout,
    input  logic              sub,
    input  logic              a_msb,
    input  logic              b_msb,
    output flags_t            flags
);

    logic sum_msb_s;

    assign sum_msb_s = sum[DATA_W-1];

    // Overflow: add overflows on like-signed operands, subtract on unlike-signed,
    // in both cases when the result sign differs from operand A.
    always_comb begin
        flags         = {FLAG_W{1'b0}};
        flags[FLAG_C] = cout;
        flags[FLAG_N] = sum_msb_s;
        flags[FLAG_Z] = (sum == {DATA_W{1'b0}});
        if (sub) begin
            flags[FLAG_V] = (a_msb != b_msb) && (sum_msb_s != a_msb);
        end else begin
            flags[FLAG_V] = (a_msb == b_msb) && (sum_msb_s != a_msb);
        end
    end

endmodule

// File: rtl/addsub_result_queue.sv
// Ready/valid FIFO of add/sub results with flags captured at push time.
// Optional statistics counters are enabled by defining ADDSUB_RQ_STATS_EN.
module addsub_result_queue
    import addsub_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter int  DATA_W = ADDSUB_DATA_W,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sum,
    input  logic              in_cout,
    input  logic              in_sub,
    input  logic              in_a_msb,
    input  logic              in_b_msb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_flags,
    output logic [CNT_W-1:0]  count
`ifdef ADDSUB_RQ_STATS_EN
    ,
    output logic [15:0]       push_cnt,
    output logic [15:0]       ovf_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] data_mem_r [DEPTH];
    flags_t            flag_mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    flags_t            in_flags_s;
    logic              push_s;
    logic              pop_s;

    addsub_flag_gen #(
        .DATA_W (DATA_W)
    ) u_flag_gen (
        .sum   (in_sum),
        .cout  (in_cout),
        .sub   (in_sub),
        .a_msb (in_a_msb),
        .b_msb (in_b_msb),
        .flags (in_flags_s)
    );

    // Handshake decode from registered occupancy only; a full queue refuses
    // a push even when the head is popped in the same cycle.
    always_comb begin
        in_ready  = (count_r != CNT_W'(DEPTH));
        out_valid = (count_r != {CNT_W{1'b0}});
        push_s    = in_valid && in_ready;
        pop_s     = out_valid && out_ready;
    end

    // Head presentation; forced to zero while empty so outputs are never stale.
    always_comb begin
        if (out_valid) begin
            out_data  = data_mem_r[rd_ptr_r];
            out_flags = flag_mem_r[rd_ptr_r];
        end else begin
            out_data  = {DATA_W{1'b0}};
            out_flags = {FLAG_W{1'b0}};
        end
    end

    assign count = count_r;

    // Entry storage written at the tail on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_r[i] <= {DATA_W{1'b0}};
                flag_mem_r[i] <= {FLAG_W{1'b0}};
            end
        end else if (push_s) begin
            data_mem_r[wr_ptr_r] <= in_sum;
            flag_mem_r[wr_ptr_r] <= in_flags_s;
        end else begin
            data_mem_r[wr_ptr_r] <= data_mem_r[wr_ptr_r];
            flag_mem_r[wr_ptr_r] <= flag_mem_r[wr_ptr_r];
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Occupancy tracking; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef ADDSUB_RQ_STATS_EN
    logic [15:0] push_cnt_r;
    logic [15:0] ovf_cnt_r;

    // Saturating counts of accepted pushes and of those carrying V=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_cnt_r <= 16'd0;
            ovf_cnt_r  <= 16'd0;
        end else if (push_s) begin
            push_cnt_r <= sat_inc16(push_cnt_r);
            if (in_flags_s[FLAG_V]) begin
                ovf_cnt_r <= sat_inc16(ovf_cnt_r);
            end
        end else begin
            push_cnt_r <= push_cnt_r;
            ovf_cnt_r  <= ovf_cnt_r;
        end
    end

    assign push_cnt = push_cnt_r;
    assign ovf_cnt  = ovf_cnt_r;
`endif

endmodule

// File: tb/tb_addsub_result_queue.sv
// Self-checking bench for addsub_result_queue: directed flag cases, full and
// wrap scenarios, asynchronous reset and randomized traffic against a queue model.
module tb_addsub_result_queue;
    import addsub_pkg::*;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 16;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [15:0] in_sum    = 16'h0000;
    logic        in_cout   = 1'b0;
    logic        in_sub    = 1'b0;
    logic        in_a_msb  = 1'b0;
    logic        in_b_msb  = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [3:0]  out_flags;
    logic [2:0]  count;
`ifdef ADDSUB_RQ_STATS_EN
    logic [15:0] push_cnt;
    logic [15:0] ovf_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Model entries are {data[15:0], C, V, N, Z}.
    logic [19:0] q[$];
    logic [19:0] cur_entry;

    addsub_result_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_cout   (in_cout),
        .in_sub    (in_sub),
        .in_a_msb  (in_a_msb),
        .in_b_msb  (in_b_msb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags),
        .count     (count)
`ifdef ADDSUB_RQ_STATS_EN
        ,
        .push_cnt  (push_cnt),
        .ovf_cnt   (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Drive an operation and compute its expected entry with integer arithmetic.
    task automatic set_op(input logic [15:0] a, input logic [15:0] b, input logic sub);
        int          sa, sb, r;
        logic [15:0] s;
        logic        c, v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = sub ? (sa - sb) : (sa + sb);
        s  = sub ? (a - b) : (a + b);
        c  = sub ? (a >= b) : ((int'(a) + int'(b)) > 65535);
        v  = (r > 32767) || (r < -32768);
        in_sum    = s;
        in_cout   = c;
        in_sub    = sub;
        in_a_msb  = a[15];
        in_b_msb  = b[15];
        cur_entry = {s, c, v, s[15], (s == 16'h0000)};
    endtask

    task automatic rand_op();
        set_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    endtask

    // One clock with the given handshake requests; the model follows the rules.
    task automatic step(input logic v, input logic r);
        bit do_push, do_pop;
        in_valid  = v;
        out_ready = r;
        do_push   = v && (q.size() != DEPTH);
        do_pop    = r && (q.size() != 0);
        @(posedge clk);
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back(cur_entry);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        q.delete();
        #2 rst_n = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b count=%0d, required 0 and 0", out_valid, count);
        end
        checks++;
        if (out_data !== 16'h0000 || out_flags !== 4'h0) begin
            errors++;
            $display("FAIL reset_head: data=%h flags=%b, required 0000 0000", out_data, out_flags);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_flags();
        set_op(16'h7FFF, 16'h0001, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_bypass: out_valid=%b before edge, required 0", out_valid);
        end
        step(1'b1, 1'b1);
        checks++;
        if (out_data !== 16'h8000 || out_flags !== 4'b0110 || out_flags !== q[0][3:0]) begin
            errors++;
            $display("FAIL add_ovf: data=%h flags=%b, required 8000 0110", out_data, out_flags);
        end
        set_op(16'h1234, 16'h1234, 1'b1);
        step(1'b1, 1'b1);
        checks++;
        if (out_data !== 16'h0000 || out_flags !== 4'b1001 || out_flags !== q[0][3:0]) begin
            errors++;
            $display("FAIL sub_zero: data=%h flags=%b, required 0000 1001", out_data, out_flags);
        end
        step(1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || count !== 3'd0) begin
            errors++;
            $display("FAIL drain_empty: valid=%b data=%h count=%0d, required 0 0000 0", out_valid, out_data, count);
        end
        step(1'b0, 1'b1);
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL pop_empty: count=%0d required 0", count);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 5; i++) begin
            rand_op();
            step(1'b1, 1'b0);
            checks++;
            if (count !== 3'(q.size()) || in_ready !== (q.size() != DEPTH)) begin
                errors++;
                $display("FAIL full_fill[%0d]: count=%0d in_ready=%b, required %0d %b",
                         i, count, in_ready, q.size(), (q.size() != DEPTH));
            end
            checks++;
            if (out_data !== q[0][19:4] || out_flags !== q[0][3:0]) begin
                errors++;
                $display("FAIL full_head_hold[%0d]: got %h/%b required %h/%b",
                         i, out_data, out_flags, q[0][19:4], q[0][3:0]);
            end
        end
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_state: count=%0d in_ready=%b, required 4 0", count, in_ready);
        end
        // Pop with push attempted while full: the push must be refused.
        rand_op();
        step(1'b1, 1'b1);
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL full_push_pop: count=%0d required 3", count);
        end
        while (q.size() != 0) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== q[0][19:4] || out_flags !== q[0][3:0]) begin
                errors++;
                $display("FAIL full_drain: valid=%b got %h/%b required %h/%b",
                         out_valid, out_data, out_flags, q[0][19:4], q[0][3:0]);
            end
            step(1'b0, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            rand_op();
            step(1'b1, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            rand_op();
            step(1'b1, 1'b1);
            checks++;
            if (count !== 3'd2 || out_data !== q[0][19:4] || out_flags !== q[0][3:0]) begin
                errors++;
                $display("FAIL b2b[%0d]: count=%0d got %h/%b required 2 %h/%b",
                         i, count, out_data, out_flags, q[0][19:4], q[0][3:0]);
            end
        end
        while (q.size() != 0) begin
            checks++;
            if (out_data !== q[0][19:4] || out_flags !== q[0][3:0]) begin
                errors++;
                $display("FAIL b2b_drain: got %h/%b required %h/%b",
                         out_data, out_flags, q[0][19:4], q[0][3:0]);
            end
            step(1'b0, 1'b1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rand_op();
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
            checks++;
            if (count !== 3'(q.size()) || out_valid !== (q.size() != 0) ||
                in_ready !== (q.size() != DEPTH)) begin
                errors++;
                $display("FAIL rand_state[%0d]: count=%0d valid=%b ready=%b, required %0d",
                         i, count, out_valid, in_ready, q.size());
            end else if (q.size() != 0) begin
                checks++;
                if (out_data !== q[0][19:4] || out_flags !== q[0][3:0]) begin
                    errors++;
                    $display("FAIL rand_head[%0d]: got %h/%b required %h/%b",
                             i, out_data, out_flags, q[0][19:4], q[0][3:0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        while (q.size() != 3) begin
            rand_op();
            step(1'b1, 1'b0);
        end
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL mid_prefill: count=%0d required 3", count);
        end
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL mid_async_reset: valid=%b count=%0d, required 0 0", out_valid, count);
        end
        #2 rst_n = 1'b1;
        set_op(16'h00AA, 16'h0000, 1'b0);
        step(1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h00AA || out_flags !== 4'b0000 || count !== 3'd1) begin
            errors++;
            $display("FAIL mid_first_push: valid=%b data=%h flags=%b count=%0d, required 1 00AA 0000 1",
                     out_valid, out_data, out_flags, count);
        end
    endtask

`ifdef ADDSUB_RQ_STATS_EN
    task automatic test_stats();
        do_reset();
        set_op(16'h7FFF, 16'h0001, 1'b0);
        step(1'b1, 1'b1);
        set_op(16'h0001, 16'h0002, 1'b0);
        step(1'b1, 1'b1);
        set_op(16'h0005, 16'h0003, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        checks++;
        if (push_cnt !== 16'd3 || ovf_cnt !== 16'd1) begin
            errors++;
            $display("FAIL stats: push_cnt=%0d ovf_cnt=%0d, required 3 1", push_cnt, ovf_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_flags();
        test_full();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef ADDSUB_RQ_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
